// File: rtl/rx_frame_pkg.sv
// Shared types and K-code constants for the 8b10b frame receiver.
package rx_frame_pkg;

    localparam logic [8:0] K28_5 = 9'h1BC;
    localparam logic [8:0] K27_7 = 9'h1FB;
    localparam logic [8:0] K29_7 = 9'h1FD;

    typedef enum logic [1:0] {
        LOS  = 2'd0,
        ACQ  = 2'd1,
        SYNC = 2'd2
    } sync_state_t;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       err;
    } fifo_entry_t;

    function automatic fifo_entry_t make_entry(input logic [7:0] data,
                                               input logic       last,
                                               input logic       err);
        fifo_entry_t e;
        e.data = data;
        e.last = last;
        e.err  = err;
        return e;
    endfunction

endpackage

// File: rtl/rx_sync_fifo.sv
// First-word-fall-through FIFO of fifo_entry_t; a write while full is accepted
// only when a read retires the head in the same cycle.
module rx_sync_fifo
    import rx_frame_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        wr_en_i,
    input  fifo_entry_t wr_data_i,
    input  logic        rd_en_i,
    output fifo_entry_t rd_data_o,
    output logic        full_o,
    output logic        empty_o
);

    localparam int AW = $clog2(DEPTH);

    fifo_entry_t       mem_q [DEPTH];
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic              do_wr, do_rd;

    // Extra pointer MSB separates full from empty when the indices match.
    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        do_rd    = rd_en_i && !empty_o;
        do_wr    = wr_en_i && (!full_o || do_rd);
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_wr};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_rd};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

endmodule

// File: rtl/rx_frame_receiver.sv
// Comma-based link sync, SOF/EOF framing and payload FIFO behind an 8b10b decoder.
// Optional RX_FRAME_STATS_EN adds saturating frame and bad-symbol counters.
module rx_frame_receiver
    import rx_frame_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int ACQ_COMMAS = 4,
    parameter int ERR_LIMIT  = 4,
    parameter int GOOD_RUN   = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [8:0]  sym_i,
    input  logic        sym_strb_i,
    input  logic        code_err_i,
    input  logic        disp_err_i,
    output logic [7:0]  m_data_o,
    output logic        m_last_o,
    output logic        m_err_o,
    output logic        m_valid_o,
    input  logic        m_ready_i,
    output logic        sync_o,
    output logic        frm_err_o,
    output logic        ovf_o,
    output sync_state_t dbg_state_o
`ifdef RX_FRAME_STATS_EN
    ,
    output logic [15:0] frm_cnt_o,
    output logic [15:0] err_cnt_o
`endif
);

    localparam int CCW = $clog2(ACQ_COMMAS + 1);
    localparam int EW  = $clog2(ERR_LIMIT + 1);
    localparam int GW  = $clog2(GOOD_RUN + 1);
    localparam logic [CCW-1:0] ACQ_N  = CCW'(ACQ_COMMAS);
    localparam logic [EW-1:0]  ERR_N  = EW'(ERR_LIMIT);
    localparam logic [GW-1:0]  GOOD_N = GW'(GOOD_RUN);

    sync_state_t    state_q, state_d;
    logic [CCW-1:0] comma_q, comma_d, comma_inc;
    logic [EW-1:0]  serr_q, serr_d;
    logic [GW-1:0]  good_q, good_d, good_inc;
    logic           sync_q, sync_d;
    logic           in_frame_q, in_frame_d;
    logic [7:0]     hold_q, hold_d;
    logic           hold_vld_q, hold_vld_d;
    logic           drop_q, drop_d;
    logic           push_q, push_d;
    fifo_entry_t    push_entry_q, push_entry_d;
    logic           frm_err_q, ovf_q;

    logic           bad, is_comma, in_sync, leave_sync;
    logic           abort, sof_start, eof_end;
    logic           fifo_full, fifo_empty, pop, ovf_now;
    fifo_entry_t    wr_entry, head;

    assign bad        = code_err_i || disp_err_i;
    assign is_comma   = (sym_i == K28_5);
    assign in_sync    = (state_q == SYNC);
    assign leave_sync = in_sync && (serr_q == ERR_N);
    assign comma_inc  = comma_q + 1'b1;
    assign good_inc   = good_q + 1'b1;

    always_comb begin
        state_d = state_q;
        comma_d = comma_q;
        serr_d  = serr_q;
        good_d  = good_q;
        unique case (state_q)
            LOS: begin
                if (sym_strb_i && !bad && is_comma) begin
                    state_d = ACQ;
                    comma_d = CCW'(1);
                end
            end
            ACQ: begin
                if (sym_strb_i && bad) begin
                    state_d = LOS;
                    comma_d = '0;
                end else if (sym_strb_i && is_comma) begin
                    comma_d = comma_inc;
                    if (comma_inc == ACQ_N) begin
                        state_d = SYNC;
                        comma_d = '0;
                        serr_d  = '0;
                        good_d  = '0;
                    end
                end
            end
            SYNC: begin
                // The symbol arriving in the cycle that drops sync is discarded.
                if (leave_sync) begin
                    state_d = LOS;
                    serr_d  = '0;
                    good_d  = '0;
                end else if (sym_strb_i && bad) begin
                    serr_d = (serr_q == ERR_N) ? serr_q : serr_q + 1'b1;
                    good_d = '0;
                end else if (sym_strb_i) begin
                    good_d = good_inc;
                    if (good_inc == GOOD_N) begin
                        good_d = '0;
                        serr_d = (serr_q == '0) ? serr_q : serr_q - 1'b1;
                    end
                end
            end
            default: state_d = LOS;
        endcase
    end

    always_comb begin
        in_frame_d   = in_frame_q;
        hold_d       = hold_q;
        hold_vld_d   = hold_vld_q;
        push_d       = 1'b0;
        push_entry_d = '0;
        abort        = 1'b0;
        sof_start    = 1'b0;
        eof_end      = 1'b0;

        if (leave_sync) begin
            abort = in_frame_q;
        end else if (in_sync && sym_strb_i) begin
            if (in_frame_q) begin
                if (bad) begin
                    abort = 1'b1;
                end else if (sym_i == K27_7) begin
                    abort     = 1'b1;
                    sof_start = 1'b1;
                end else if (sym_i == K29_7) begin
                    eof_end = 1'b1;
                end else if (!sym_i[8]) begin
                    push_d       = hold_vld_q;
                    push_entry_d = make_entry(hold_q, 1'b0, 1'b0);
                    hold_d       = sym_i[7:0];
                    hold_vld_d   = 1'b1;
                end
            end else if (!bad && sym_i == K27_7) begin
                sof_start = 1'b1;
            end
        end

        // The held byte closes the frame; a drop earlier in the frame is ORed in at write time.
        if (abort || eof_end) begin
            push_d       = hold_vld_q;
            push_entry_d = make_entry(hold_q, 1'b1, abort);
            hold_vld_d   = 1'b0;
            in_frame_d   = 1'b0;
        end
        if (sof_start) begin
            in_frame_d = 1'b1;
            hold_vld_d = 1'b0;
        end
    end

    assign pop     = m_valid_o && m_ready_i;
    assign ovf_now = push_q && fifo_full && !pop;
    assign sync_d  = (state_d == SYNC);

    always_comb begin
        wr_entry     = push_entry_q;
        wr_entry.err = push_entry_q.err || (push_entry_q.last && drop_q);
        drop_d       = drop_q;
        if (ovf_now) begin
            drop_d = 1'b1;
        end
        if (sof_start) begin
            drop_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= LOS;
            comma_q      <= '0;
            serr_q       <= '0;
            good_q       <= '0;
            sync_q       <= 1'b0;
            in_frame_q   <= 1'b0;
            hold_q       <= '0;
            hold_vld_q   <= 1'b0;
            drop_q       <= 1'b0;
            push_q       <= 1'b0;
            push_entry_q <= '0;
            frm_err_q    <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            comma_q      <= comma_d;
            serr_q       <= serr_d;
            good_q       <= good_d;
            sync_q       <= sync_d;
            in_frame_q   <= in_frame_d;
            hold_q       <= hold_d;
            hold_vld_q   <= hold_vld_d;
            drop_q       <= drop_d;
            push_q       <= push_d;
            push_entry_q <= push_entry_d;
            frm_err_q    <= abort;
            ovf_q        <= ovf_now;
        end
    end

    rx_sync_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .wr_en_i   (push_q),
        .wr_data_i (wr_entry),
        .rd_en_i   (m_ready_i),
        .rd_data_o (head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign m_valid_o   = !fifo_empty;
    assign m_data_o    = m_valid_o ? head.data : 8'h00;
    assign m_last_o    = m_valid_o && head.last;
    assign m_err_o     = m_valid_o && head.err;
    assign sync_o      = sync_q;
    assign frm_err_o   = frm_err_q;
    assign ovf_o       = ovf_q;
    assign dbg_state_o = state_q;

`ifdef RX_FRAME_STATS_EN
    logic [15:0] stat_frm_q, stat_frm_d;
    logic [15:0] stat_err_q, stat_err_d;

    always_comb begin
        stat_frm_d = stat_frm_q;
        stat_err_d = stat_err_q;
        if (eof_end && stat_frm_q != 16'hFFFF) begin
            stat_frm_d = stat_frm_q + 16'd1;
        end
        if (sym_strb_i && bad && stat_err_q != 16'hFFFF) begin
            stat_err_d = stat_err_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_frm_q <= '0;
            stat_err_q <= '0;
        end else begin
            stat_frm_q <= stat_frm_d;
            stat_err_q <= stat_err_d;
        end
    end

    assign frm_cnt_o = stat_frm_q;
    assign err_cnt_o = stat_err_q;
`endif

endmodule
